// File: rtl/id_exec_control_pkg.sv
// id_exec_control_pkg: shared ALU command, mode and condition codes plus the ID/EX control record
package id_exec_control_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_MOV = 4'b0001;
    localparam logic [3:0] ALU_MVN = 4'b1001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_ADC = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SBC = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_ORR = 4'b0111;
    localparam logic [3:0] ALU_EOR = 4'b1000;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       branch;
        logic       s_update;
        logic       valid;
        logic       illegal;
    } ex_ctrl_t;

    function automatic ex_ctrl_t bubble(input logic ill);
        bubble = '0;
        bubble.illegal = ill;
    endfunction

endpackage

// File: rtl/id_exec_control_if.sv
// id_exec_control_if: decode-stage inputs, hazard controls, ALU flags and EX-stage controls
interface id_exec_control_if;
    logic       id_valid;
    logic [1:0] id_mode;
    logic [3:0] id_opcode;
    logic       id_s;
    logic [3:0] id_cond;
    logic       freeze;
    logic       flush;
    logic       alu_n;
    logic       alu_z;
    logic       alu_c;
    logic       alu_v;
    logic [3:0] ex_exec_command;
    logic       ex_mem_read;
    logic       ex_mem_write;
    logic       ex_wb_en;
    logic       ex_branch;
    logic       ex_s_update;
    logic       ex_valid;
    logic       ex_illegal;
    logic       carry_in;
    logic [3:0] status;

    modport master (
        output id_valid, id_mode, id_opcode, id_s, id_cond, freeze, flush,
               alu_n, alu_z, alu_c, alu_v,
        input  ex_exec_command, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch,
               ex_s_update, ex_valid, ex_illegal, carry_in, status
    );

    modport slave (
        input  id_valid, id_mode, id_opcode, id_s, id_cond, freeze, flush,
               alu_n, alu_z, alu_c, alu_v,
        output ex_exec_command, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch,
               ex_s_update, ex_valid, ex_illegal, carry_in, status
    );
endinterface

// File: rtl/id_exec_control_cond_check.sv
// cond_check: ARM condition-field evaluation against {N,Z,C,V}
module cond_check
    import id_exec_control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = flags;

    // Condition table; the reserved code 1111 never passes
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = !w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = !w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = !w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = !w_v;
            COND_HI: pass = w_c && !w_z;
            COND_LS: pass = !w_c || w_z;
            COND_GE: pass = w_n == w_v;
            COND_LT: pass = w_n != w_v;
            COND_GT: pass = !w_z && (w_n == w_v);
            COND_LE: pass = w_z || (w_n != w_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/id_exec_control.sv
// id_exec_control: decode, condition check, ID/EX control register and status register
module id_exec_control
    import id_exec_control_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    id_exec_control_if.slave  bus
);
    ex_ctrl_t   r_ex;
    logic [3:0] r_status;
    ex_ctrl_t   w_dec;
    ex_ctrl_t   w_next;
    logic [3:0] w_dp_cmd;
    logic       w_dp_ok;
    logic       w_dp_cmp;
    logic [3:0] w_alu;
    logic [3:0] w_eff;
    logic       w_writer;
    logic       w_pass;

    assign w_alu    = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
    assign w_writer = r_ex.valid && r_ex.s_update;
    // The instruction in EX has not yet written status, so its flags are forwarded
    assign w_eff    = w_writer ? w_alu : r_status;
    assign w_dp_cmp = (bus.id_opcode == OP_CMP) || (bus.id_opcode == OP_TST);

    cond_check u_cond (
        .cond  (bus.id_cond),
        .flags (w_eff),
        .pass  (w_pass)
    );

    // Data-processing opcode to ALU command map; unmapped opcodes flag illegal
    always_comb begin
        w_dp_cmd = ALU_NOP;
        w_dp_ok  = 1'b1;
        case (bus.id_opcode)
            OP_MOV:  w_dp_cmd = ALU_MOV;
            OP_MVN:  w_dp_cmd = ALU_MVN;
            OP_ADD:  w_dp_cmd = ALU_ADD;
            OP_ADC:  w_dp_cmd = ALU_ADC;
            OP_SUB:  w_dp_cmd = ALU_SUB;
            OP_SBC:  w_dp_cmd = ALU_SBC;
            OP_AND:  w_dp_cmd = ALU_AND;
            OP_ORR:  w_dp_cmd = ALU_ORR;
            OP_EOR:  w_dp_cmd = ALU_EOR;
            OP_CMP:  w_dp_cmd = ALU_SUB;
            OP_TST:  w_dp_cmd = ALU_AND;
            default: w_dp_ok  = 1'b0;
        endcase
    end

    // Mode decode into the EX control record
    always_comb begin
        w_dec       = '0;
        w_dec.valid = 1'b1;
        case (bus.id_mode)
            MODE_DP: begin
                w_dec.cmd      = w_dp_cmd;
                w_dec.wb_en    = !w_dp_cmp;
                w_dec.s_update = bus.id_s || w_dp_cmp;
            end
            MODE_MEM: begin
                w_dec.cmd       = ALU_ADD;
                w_dec.mem_read  = bus.id_s;
                w_dec.mem_write = !bus.id_s;
                w_dec.wb_en     = bus.id_s;
            end
            MODE_BR: w_dec.branch = 1'b1;
            default: w_dec = bubble(1'b1);
        endcase
        if (bus.id_mode == MODE_DP && !w_dp_ok) w_dec = bubble(1'b1);
    end

    // Flush beats freeze beats capture; squashed or unpredicated slots become clean bubbles
    always_comb begin
        w_next = bus.flush                 ? bubble(1'b0) :
                 bus.freeze                ? r_ex :
                 (!bus.id_valid || !w_pass) ? bubble(1'b0) : w_dec;
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ex <= '0;
        else        r_ex <= w_next;
    end

    // Status register takes the EX flags whenever a flag writer retires, freeze or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_status <= '0;
        else if (w_writer && !bus.flush) r_status <= w_alu;
    end

    assign bus.ex_exec_command = r_ex.cmd;
    assign bus.ex_mem_read     = r_ex.mem_read;
    assign bus.ex_mem_write    = r_ex.mem_write;
    assign bus.ex_wb_en        = r_ex.wb_en;
    assign bus.ex_branch       = r_ex.branch;
    assign bus.ex_s_update     = r_ex.s_update;
    assign bus.ex_valid        = r_ex.valid;
    assign bus.ex_illegal      = r_ex.illegal;
    assign bus.status          = r_status;
    assign bus.carry_in        = r_status[1];
endmodule

// File: tb/tb_id_exec_control.sv
// tb_id_exec_control: directed scenarios plus random traffic against a table-driven reference model
module tb_id_exec_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    id_exec_control_if bus ();

    id_exec_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ALU command per data-processing opcode, -1 = undecodable
    int dp_map [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    logic [3:0] m_cmd, m_status;
    logic       m_rd, m_wr, m_wb, m_br, m_s, m_v, m_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {bus.ex_exec_command, bus.ex_mem_read, bus.ex_mem_write, bus.ex_wb_en,
                bus.ex_branch, bus.ex_s_update, bus.ex_valid, bus.ex_illegal,
                bus.status, bus.carry_in};
    endfunction

    function automatic logic [15:0] model_vec();
        return {m_cmd, m_rd, m_wr, m_wb, m_br, m_s, m_v, m_ill, m_status, m_status[1]};
    endfunction

    function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            0: return z;
            1: return !z;
            2: return c;
            3: return !c;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            8: return c && !z;
            9: return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_bubble(input logic ill);
        {m_cmd, m_rd, m_wr, m_wb, m_br, m_s, m_v} = '0;
        m_ill = ill;
    endtask

    task automatic drive(input logic v, input logic [1:0] mode, input logic [3:0] op,
                         input logic s, input logic [3:0] cond, input logic frz,
                         input logic fl, input logic [3:0] flags);
        bus.id_valid  = v;
        bus.id_mode   = mode;
        bus.id_opcode = op;
        bus.id_s      = s;
        bus.id_cond   = cond;
        bus.freeze    = frz;
        bus.flush     = fl;
        {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = flags;
    endtask

    // Advance the model by one edge from the present inputs, then compare after the edge
    task automatic cyc(input string tag);
        logic [3:0] alu, eff, ns;
        bit writer;
        alu    = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
        writer = m_v && m_s;
        eff    = writer ? alu : m_status;
        ns     = (writer && !bus.flush) ? alu : m_status;
        if (bus.flush) model_bubble(1'b0);
        else if (bus.freeze) ;
        else if (!bus.id_valid || !cond_ok(bus.id_cond, eff)) model_bubble(1'b0);
        else if (bus.id_mode == 2'd3) model_bubble(1'b1);
        else if (bus.id_mode == 2'd0) begin
            if (dp_map[bus.id_opcode] < 0) model_bubble(1'b1);
            else begin
                model_bubble(1'b0);
                m_cmd = 4'(dp_map[bus.id_opcode]);
                m_wb  = (bus.id_opcode != 4'd10) && (bus.id_opcode != 4'd8);
                m_s   = bus.id_s || !m_wb;
                m_v   = 1'b1;
            end
        end else if (bus.id_mode == 2'd1) begin
            model_bubble(1'b0);
            m_cmd = 4'd2;
            m_rd  = bus.id_s;
            m_wr  = !bus.id_s;
            m_wb  = bus.id_s;
            m_v   = 1'b1;
        end else begin
            model_bubble(1'b0);
            m_br = 1'b1;
            m_v  = 1'b1;
        end
        m_status = ns;
        @(posedge clk);
        #1;
        check(tag, dut_vec(), model_vec());
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        model_bubble(1'b0);
        m_status = '0;
        #1;
        check("rst_now", dut_vec(), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1, 0, 4'd4, 1, 4'he, 0, 0, 4'hf);
        model_bubble(1'b0);
        m_status = '0;
        #2;
        check("rst_init", dut_vec(), 16'h0);
        @(posedge clk);
        #1;
        check("rst_edge", dut_vec(), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 0, 4'd4, 1, 4'he, 0, 0, 4'h0);
        cyc("add");
        check("add_cmd", bus.ex_exec_command, 4'b0010);
        check("add_ctl", {bus.ex_wb_en, bus.ex_s_update, bus.ex_valid}, 3'b111);

        drive(1, 0, 4'd10, 0, 4'he, 0, 0, 4'h0);
        cyc("cmp");
        drive(1, 2, 4'd0, 0, 4'h0, 0, 0, 4'b0100);
        cyc("beq");
        check("beq_br", bus.ex_branch, 1'b1);
        check("beq_status", bus.status, 4'b0100);

        reset_dut();
        drive(1, 0, 4'd13, 0, 4'h1, 0, 0, 4'b0100);
        cyc("movne");
        check("movne_cmd", bus.ex_exec_command, 4'b0001);
        drive(1, 0, 4'd10, 0, 4'he, 0, 0, 4'h0);
        cyc("cmp2");
        drive(1, 0, 4'd13, 0, 4'h1, 0, 0, 4'b0100);
        cyc("movne_byp");
        check("movne_byp_v", bus.ex_valid, 1'b0);
        drive(1, 0, 4'd13, 0, 4'h1, 0, 0, 4'b0000);
        cyc("movne_stat");
        check("movne_stat_v", bus.ex_valid, 1'b0);

        drive(1, 1, 4'd0, 1, 4'he, 0, 0, 4'h0);
        cyc("ldr");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 4'($urandom), 0, 4'he, 1, 0, 4'($urandom));
            cyc("ldr_frz");
            check("ldr_frz_ctl", {bus.ex_exec_command, bus.ex_mem_read, bus.ex_wb_en, bus.ex_valid},
                  7'b0010_111);
        end
        drive(1, 1, 4'd0, 1, 4'he, 1, 1, 4'h0);
        cyc("ldr_flush");
        check("ldr_flush_v", {bus.ex_valid, bus.ex_illegal, bus.ex_mem_read}, 3'b000);

        drive(1, 3, 4'd4, 0, 4'he, 0, 0, 4'h0);
        cyc("mode3");
        check("mode3_ill", {bus.ex_illegal, bus.ex_valid}, 2'b10);
        drive(1, 0, 4'd3, 0, 4'he, 0, 0, 4'h0);
        cyc("op3");
        check("op3_ill", {bus.ex_illegal, bus.ex_valid}, 2'b10);

        drive(1, 0, 4'd4, 1, 4'he, 0, 0, 4'h0);
        cyc("adds");
        drive(1, 0, 4'd4, 1, 4'he, 0, 0, 4'hf);
        #3;
        rst_n = 1'b0;
        model_bubble(1'b0);
        m_status = '0;
        #1;
        check("rst_mid", dut_vec(), 16'h0);
        @(posedge clk);
        #1;
        check("rst_mid_stat", bus.status, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 8) != 0, 2'($urandom), 4'($urandom), 1'($urandom),
                  ($urandom % 3 == 0) ? 4'he : 4'($urandom),
                  ($urandom % 6) == 0, ($urandom % 8) == 0, 4'($urandom));
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
